// File: rtl/triode_off_tally.sv
// triode_off_tally
// Sums the per-flip-flop "triodes off" counts every U cycle and accumulates
// those sums over a programmable window of enabled cycles. When a window
// closes, a snapshot (total, peak, cycle count, overflow) is posted to the
// register side and held until the consumer acknowledges it.
//
// Snapshot handshake (valid/ack):
//   snap_valid rises on the edge a window closes and stays high until an
//   edge where snap_ack=1 and no new window closes. snap_ack while
//   snap_valid=0 has no effect. If a window closes on the same edge as
//   snap_ack, the new snapshot is loaded and snap_valid stays high. If a
//   window closes while snap_valid=1 and snap_ack=0, the old snapshot is
//   overwritten and the sticky snap_lost flag is set until RESET.
//
// Pipeline: S1 registers the inputs, S2 registers the adder-tree sum, S3
// accumulates. A sample presented at edge n updates S3 state at edge n+2.
module triode_off_tally #(
    parameter  int NDFF = 16,
    parameter  int WINW = 16,
    parameter  int ACCW = 32,
    localparam int SW   = $clog2(6 * NDFF + 1)
) (
    input  logic                 U,
    input  logic                 RESET,
    input  logic [3*NDFF-1:0]    nto_bus,
    input  logic                 en,
    input  logic [WINW-1:0]      win_len,
    output logic                 snap_valid,
    input  logic                 snap_ack,
    output logic [ACCW-1:0]      snap_total,
    output logic [SW-1:0]        snap_peak,
    output logic [WINW-1:0]      snap_cycles,
    output logic                 snap_ovf,
    output logic                 snap_lost
);

    // S1 registers
    logic [3*NDFF-1:0] bus_s1;
    logic              en_s1;

    // S2 registers
    logic [SW-1:0]     sum_s2;
    logic              en_s2;

    // S3 window state
    logic [ACCW-1:0]   acc;
    logic [SW-1:0]     peak;
    logic [WINW-1:0]   cnt;
    logic              ovf;

    // Combinational S2 and S3 next values
    logic [SW-1:0]     tree_sum;
    logic [ACCW:0]     acc_wide;
    logic [ACCW-1:0]   acc_next;
    logic              ovf_next;
    logic [SW-1:0]     peak_next;
    logic [WINW-1:0]   cnt_next;
    logic              close;

    // S1: capture the raw count bus and its qualifier
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            bus_s1 <= '0;
            en_s1  <= 1'b0;
        end else begin
            bus_s1 <= nto_bus;
            en_s1  <= en;
        end
    end

    // Adder tree over the registered counts; illegal 7s are summed as-is
    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < NDFF; k++) begin
            tree_sum = tree_sum + SW'(bus_s1[3*k +: 3]);
        end
    end

    // S2: register the per-cycle sum with its qualifier
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            sum_s2 <= '0;
            en_s2  <= 1'b0;
        end else begin
            sum_s2 <= tree_sum;
            en_s2  <= en_s1;
        end
    end

    // S3 next values: saturating accumulate, running peak, cycle count and
    // the close decision; >= lets a lowered win_len close the window at once
    always_comb begin
        acc_wide  = {1'b0, acc} + (ACCW + 1)'(sum_s2);
        acc_next  = acc_wide[ACCW] ? {ACCW{1'b1}} : acc_wide[ACCW-1:0];
        ovf_next  = ovf | acc_wide[ACCW];
        peak_next = (sum_s2 > peak) ? sum_s2 : peak;
        cnt_next  = cnt + WINW'(1);
        close     = en_s2 && (win_len != '0) && (cnt_next >= win_len);
    end

    // S3: window accumulation, cleared on close; disabled samples change nothing
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            acc  <= '0;
            peak <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (en_s2) begin
            if (close) begin
                acc  <= '0;
                peak <= '0;
                cnt  <= '0;
                ovf  <= 1'b0;
            end else begin
                acc  <= acc_next;
                peak <= peak_next;
                cnt  <= cnt_next;
                ovf  <= ovf_next;
            end
        end
    end

    // Snapshot registers: loaded with the updated window values on close
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            snap_total  <= '0;
            snap_peak   <= '0;
            snap_cycles <= '0;
            snap_ovf    <= 1'b0;
        end else if (close) begin
            snap_total  <= acc_next;
            snap_peak   <= peak_next;
            snap_cycles <= cnt_next;
            snap_ovf    <= ovf_next;
        end
    end

    // Handshake state: valid set on close, cleared by ack; lost is sticky
    always_ff @(posedge U or posedge RESET) begin
        if (RESET) begin
            snap_valid <= 1'b0;
            snap_lost  <= 1'b0;
        end else begin
            if (close) begin
                snap_valid <= 1'b1;
                if (snap_valid && !snap_ack) begin
                    snap_lost <= 1'b1;
                end
            end else if (snap_ack) begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_triode_off_tally.sv
// Bench for triode_off_tally: a wide (ACCW=32) and a narrow (ACCW=8) instance
// share one stimulus stream. A window-level model tracks the expected
// snapshot of both and is compared against every output on each negedge;
// directed literal checks pin the model on the key scenarios.
module tb_triode_off_tally;

    localparam int NDFF = 16;
    localparam int WINW = 16;
    localparam int SW   = $clog2(6 * NDFF + 1);

    logic                U = 1'b0;
    logic                RESET = 1'b1;
    logic [3*NDFF-1:0]   nto_bus = '0;
    logic                en = 1'b0;
    logic                snap_ack = 1'b0;
    logic [WINW-1:0]     win_len = '0;

    logic                w_valid, w_ovf, w_lost;
    logic [31:0]         w_total;
    logic [SW-1:0]       w_peak;
    logic [WINW-1:0]     w_cycles;

    logic                n_valid, n_ovf, n_lost;
    logic [7:0]          n_total;
    logic [SW-1:0]       n_peak;
    logic [WINW-1:0]     n_cycles;

    triode_off_tally #(.NDFF(NDFF), .WINW(WINW), .ACCW(32)) dut_w (
        .U(U), .RESET(RESET), .nto_bus(nto_bus), .en(en), .win_len(win_len),
        .snap_valid(w_valid), .snap_ack(snap_ack), .snap_total(w_total),
        .snap_peak(w_peak), .snap_cycles(w_cycles), .snap_ovf(w_ovf),
        .snap_lost(w_lost)
    );

    triode_off_tally #(.NDFF(NDFF), .WINW(WINW), .ACCW(8)) dut_n (
        .U(U), .RESET(RESET), .nto_bus(nto_bus), .en(en), .win_len(win_len),
        .snap_valid(n_valid), .snap_ack(snap_ack), .snap_total(n_total),
        .snap_peak(n_peak), .snap_cycles(n_cycles), .snap_ovf(n_ovf),
        .snap_lost(n_lost)
    );

    // Clock
    always #5 U = ~U;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level model ----------------
    longint maxv [2] = '{64'd4294967295, 64'd255};
    longint m_acc [2];
    longint m_ovf [2];
    longint m_stot [2];
    longint m_sovf [2];
    longint m_peak, m_cnt, m_speak, m_scyc, m_valid, m_lost;
    int     q_sum [$];
    bit     q_en  [$];

    function automatic int bus_sum(input logic [3*NDFF-1:0] b);
        int s = 0;
        for (int k = 0; k < NDFF; k++) s += int'(b[3*k +: 3]);
        return s;
    endfunction

    function automatic logic [3*NDFF-1:0] make_bus(input int s);
        logic [3*NDFF-1:0] b = '0;
        int rem = s;
        for (int k = 0; k < NDFF; k++) begin
            int f = (rem > 6) ? 6 : rem;
            b[3*k +: 3] = 3'(f);
            rem -= f;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_acc[w] = 0; m_ovf[w] = 0; m_stot[w] = 0; m_sovf[w] = 0;
        end
        m_peak = 0; m_cnt = 0; m_speak = 0; m_scyc = 0; m_valid = 0; m_lost = 0;
        q_sum.delete();
        q_en.delete();
    endtask

    task automatic apply(input int s, input bit e);
        longint nc;
        bit cl;
        cl = 1'b0;
        if (e) begin
            for (int w = 0; w < 2; w++) begin
                if (m_acc[w] + s > maxv[w]) begin
                    m_acc[w] = maxv[w];
                    m_ovf[w] = 1;
                end else begin
                    m_acc[w] = m_acc[w] + s;
                end
            end
            if (s > m_peak) m_peak = s;
            nc = m_cnt + 1;
            cl = (win_len != 0) && (nc >= longint'(win_len));
            m_cnt = nc % 65536;
            if (cl) begin
                for (int w = 0; w < 2; w++) begin
                    m_stot[w] = m_acc[w]; m_sovf[w] = m_ovf[w];
                    m_acc[w] = 0; m_ovf[w] = 0;
                end
                m_speak = m_peak; m_scyc = m_cnt;
                m_peak = 0; m_cnt = 0;
                if (m_valid != 0 && !snap_ack) m_lost = 1;
                m_valid = 1;
            end
        end
        if (!cl && snap_ack) m_valid = 0;
    endtask

    // Model steps on the same edges as the DUT; each sample lands two edges later
    always @(posedge U or posedge RESET) begin
        if (RESET) begin
            model_reset();
        end else begin
            q_sum.push_back(bus_sum(nto_bus));
            q_en.push_back(en);
            if (q_sum.size() > 2) apply(q_sum.pop_front(), q_en.pop_front());
        end
    end

    // Compare every output of both instances on each negedge
    always @(negedge U) begin
        chk("w_valid",  64'(w_valid),  64'(m_valid));
        chk("w_total",  64'(w_total),  64'(m_stot[0]));
        chk("w_peak",   64'(w_peak),   64'(m_speak));
        chk("w_cycles", 64'(w_cycles), 64'(m_scyc));
        chk("w_ovf",    64'(w_ovf),    64'(m_sovf[0]));
        chk("w_lost",   64'(w_lost),   64'(m_lost));
        chk("n_valid",  64'(n_valid),  64'(m_valid));
        chk("n_total",  64'(n_total),  64'(m_stot[1]));
        chk("n_peak",   64'(n_peak),   64'(m_speak));
        chk("n_cycles", 64'(n_cycles), 64'(m_scyc));
        chk("n_ovf",    64'(n_ovf),    64'(m_sovf[1]));
        chk("n_lost",   64'(n_lost),   64'(m_lost));
    end

    // ---------------- driver tasks ----------------
    task automatic drive_raw(input logic [3*NDFF-1:0] b, input bit e, input bit a);
        @(negedge U);
        nto_bus  = b;
        en       = e;
        snap_ack = a;
    endtask

    task automatic drive(input int s, input bit e, input bit a);
        drive_raw(make_bus(s), e, a);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [3*NDFF-1:0] sevens;
        sevens = '1;
        model_reset();
        RESET = 1'b1;
        repeat (2) @(negedge U);
        RESET = 1'b0;

        // T1: async reset mid-window with live inputs
        win_len = 16'd1;
        repeat (4) drive(50, 1'b1, 1'b0);
        chk("t1_valid_pre", 64'(w_valid), 64'd1);
        chk("t1_total_pre", 64'(w_total), 64'd50);
        #2 RESET = 1'b1;
        #1;
        chk("t1_valid_rst", 64'(w_valid), 64'd0);
        chk("t1_total_rst", 64'(w_total), 64'd0);
        chk("t1_peak_rst",  64'(w_peak),  64'd0);
        chk("t1_cyc_rst",   64'(w_cycles), 64'd0);
        chk("t1_lost_rst",  64'(w_lost),  64'd0);
        chk("t1_ntot_rst",  64'(n_total), 64'd0);
        @(negedge U);
        RESET = 1'b0;
        en = 1'b0;
        nto_bus = '0;
        win_len = 16'd2;
        drive(20, 1'b1, 1'b0);
        drive(4, 1'b1, 1'b0);
        idle(3);
        chk("t1_total_post", 64'(w_total), 64'd24);
        chk("t1_peak_post",  64'(w_peak),  64'd20);
        chk("t1_cyc_post",   64'(w_cycles), 64'd2);
        drive(0, 1'b0, 1'b1);

        // T2: latency with win_len=1, all counts 6
        win_len = 16'd1;
        drive(96, 1'b1, 1'b0);
        idle(2);
        chk("t2_valid_early", 64'(w_valid), 64'd0);
        idle(1);
        chk("t2_valid",  64'(w_valid),  64'd1);
        chk("t2_total",  64'(w_total),  64'd96);
        chk("t2_peak",   64'(w_peak),   64'd96);
        chk("t2_cycles", 64'(w_cycles), 64'd1);
        drive(0, 1'b0, 1'b1);
        idle(1);
        chk("t2_acked", 64'(w_valid), 64'd0);

        // T3: window of 4 with disabled samples mixed in
        win_len = 16'd4;
        drive(10, 1'b1, 1'b0);
        drive(90, 1'b0, 1'b0);
        drive(0,  1'b1, 1'b0);
        drive(90, 1'b0, 1'b0);
        drive(30, 1'b1, 1'b0);
        drive(5,  1'b1, 1'b0);
        idle(3);
        chk("t3_total",  64'(w_total),  64'd45);
        chk("t3_peak",   64'(w_peak),   64'd30);
        chk("t3_cycles", 64'(w_cycles), 64'd4);
        drive(0, 1'b0, 1'b1);

        // T4a: no ack, second close sets lost
        win_len = 16'd2;
        repeat (4) drive(10, 1'b1, 1'b0);
        idle(3);
        chk("t4_lost",  64'(w_lost),  64'd1);
        chk("t4_total", 64'(w_total), 64'd20);
        idle(4);
        chk("t4_lost_sticky", 64'(w_lost), 64'd1);
        #2 RESET = 1'b1;
        @(negedge U);
        RESET = 1'b0;

        // T4b: ack on every close edge
        for (int i = 0; i < 8; i++) drive(10, i < 6, (i == 3) || (i == 5) || (i == 7));
        idle(1);
        chk("t4b_lost",  64'(w_lost),  64'd0);
        chk("t4b_valid", 64'(w_valid), 64'd1);
        chk("t4b_total", 64'(w_total), 64'd20);
        drive(0, 1'b0, 1'b1);

        // T5: saturation in the narrow build, wide build for contrast
        win_len = 16'd10;
        repeat (10) drive(96, 1'b1, 1'b0);
        idle(3);
        chk("t5_ntotal", 64'(n_total), 64'd255);
        chk("t5_novf",   64'(n_ovf),   64'd1);
        chk("t5_wtotal", 64'(w_total), 64'd960);
        chk("t5_wovf",   64'(w_ovf),   64'd0);
        chk("t5_cycles", 64'(n_cycles), 64'd10);
        drive(0, 1'b0, 1'b1);
        repeat (10) drive(1, 1'b1, 1'b0);
        idle(3);
        chk("t5_ntotal2", 64'(n_total), 64'd10);
        chk("t5_novf2",   64'(n_ovf),   64'd0);
        drive(0, 1'b0, 1'b1);

        // T6: win_len lowered mid-window
        win_len = 16'd8;
        repeat (5) drive(2, 1'b1, 1'b0);
        idle(3);
        chk("t6_no_close", 64'(w_valid), 64'd0);
        win_len = 16'd3;
        drive(2, 1'b1, 1'b0);
        idle(3);
        chk("t6_valid",  64'(w_valid),  64'd1);
        chk("t6_cycles", 64'(w_cycles), 64'd6);
        chk("t6_total",  64'(w_total),  64'd12);
        drive(0, 1'b0, 1'b1);

        // T7: free-run with illegal 7s, then close by setting win_len
        win_len = 16'd0;
        repeat (3) drive_raw(sevens, 1'b1, 1'b0);
        idle(3);
        chk("t7_free_run", 64'(w_valid), 64'd0);
        win_len = 16'd4;
        drive_raw(sevens, 1'b1, 1'b0);
        idle(3);
        chk("t7_total",  64'(w_total),  64'd448);
        chk("t7_peak",   64'(w_peak),   64'd112);
        chk("t7_cycles", 64'(w_cycles), 64'd4);
        chk("t7_ntotal", 64'(n_total),  64'd255);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
